ps2_kbd_event_ctrl: RTL and testbench

//  PS/2 keyboard front end: synchronises ps2_clk/ps2_data and receives 11-bit frames.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_kbd_event_ctrl_if.sv | 16 +
 rtl/seg7_hex.sv | 39 +++
 rtl/ps2_kbd_event_ctrl.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ps2_kbd_event_ctrl.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard event controller.
package ps2_pkg;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Active-high "all segments off" pattern; polarity is applied per display.
    localparam logic [7:0] SEG_OFF = 8'h00;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

endpackage

// File: rtl/ps2_kbd_event_ctrl_if.sv
// Consumer-side event stream of the PS/2 keyboard controller.
interface ps2_kbd_event_ctrl_if;
    // Handshake: the head event (ev_code/ev_ext/ev_break) is stable while ev_valid
    // is high; it is consumed on any rising clk edge where ev_valid && ev_ready.
    // ev_valid never depends on ev_ready, and ev_ready may be held high freely.
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;

    modport master (output ev_valid, output ev_code, output ev_ext, output ev_break,
                    input  ev_ready);
    modport slave  (input  ev_valid, input  ev_code, input  ev_ext, input  ev_break,
                    output ev_ready);
endinterface

// File: rtl/seg7_hex.sv
// One hex digit to a {dp,g,f,e,d,c,b,a} segment pattern with blanking and polarity.
module seg7_hex
    import ps2_pkg::*;
(
    input  logic [3:0] hex_i,
    input  logic       blank_i,
    input  logic       act_low_i,
    output logic [7:0] seg_o
);

    logic [7:0] pat;

    always_comb begin
        pat = SEG_OFF;
        case (hex_i)
            4'h0: pat = 8'h3F;
            4'h1: pat = 8'h06;
            4'h2: pat = 8'h5B;
            4'h3: pat = 8'h4F;
            4'h4: pat = 8'h66;
            4'h5: pat = 8'h6D;
            4'h6: pat = 8'h7D;
            4'h7: pat = 8'h07;
            4'h8: pat = 8'h7F;
            4'h9: pat = 8'h6F;
            4'hA: pat = 8'h77;
            4'hB: pat = 8'h7C;
            4'hC: pat = 8'h39;
            4'hD: pat = 8'h5E;
            4'hE: pat = 8'h79;
            default: pat = 8'h71;
        endcase
        if (blank_i) begin
            pat = SEG_OFF;
        end
        seg_o = act_low_i ? ~pat : pat;
    end

endmodule

// File: rtl/ps2_kbd_event_ctrl.sv
// PS/2 keyboard receiver: frame check, E0/F0 decode, event FIFO, held-key
// tracking, press counter and six-digit 7-segment readout.
module ps2_kbd_event_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int SEG_ACT_LOW = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    ps2_kbd_event_ctrl_if.master            ev,
    output logic [CNT_W-1:0]                press_cnt,
    output logic                            err_frame,
    output logic                            err_ovf,
    output logic [7:0]                      seg0,
    output logic [7:0]                      seg1,
    output logic [7:0]                      seg2,
    output logic [7:0]                      seg3,
    output logic [7:0]                      seg4,
    output logic [7:0]                      seg5,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] ev_count,
    output rx_state_t                       rx_state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0] SEG_RST = (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    // Synchronisers reset to the idle-high line level so reset never fakes a fall.
    logic [2:0] clk_s_q, dat_s_q;
    logic       fall_det, rx_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s_q <= 3'b111;
            dat_s_q <= 3'b111;
        end else begin
            clk_s_q <= {clk_s_q[1:0], ps2_clk};
            dat_s_q <= {dat_s_q[1:0], ps2_data};
        end
    end

    assign fall_det = clk_s_q[2] & ~clk_s_q[1];
    assign rx_bit   = dat_s_q[2];

    rx_state_t       state_q, state_d;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt_q;
    logic            par_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            timeout, frame_ok, frame_bad;

    assign timeout      = (state_q != RX_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYC));
    assign rx_state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = RX_IDLE;
        end else if (fall_det) begin
            case (state_q)
                RX_IDLE:   if (!rx_bit) state_d = RX_DATA;
                RX_DATA:   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = timeout;
        if (fall_det && state_q == RX_STOP) begin
            if (rx_bit && (^{shift_q, par_q})) begin
                frame_ok = 1'b1;
            end else begin
                frame_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
        end else if (fall_det) begin
            case (state_q)
                RX_IDLE: bit_cnt_q <= '0;
                RX_DATA: begin
                    shift_q   <= {rx_bit, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                RX_PARITY: par_q <= rx_bit;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || fall_det || state_q == RX_IDLE) begin
            to_cnt_q <= '0;
        end else if (!timeout) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Accepted byte is registered; decode and FIFO push happen one cycle later.
    logic       acc_q, ext_f_q, brk_f_q, ev_push;
    logic [7:0] byte_q;
    kbd_event_t ev_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= 1'b0;
            byte_q <= '0;
        end else begin
            acc_q <= frame_ok;
            if (frame_ok) begin
                byte_q <= shift_q;
            end
        end
    end

    assign ev_push = acc_q && (byte_q != SC_EXT) && (byte_q != SC_BRK);
    assign ev_new  = '{ext: ext_f_q, brk: brk_f_q, code: byte_q};

    always_ff @(posedge clk) begin
        if (rst || frame_bad) begin
            ext_f_q <= 1'b0;
            brk_f_q <= 1'b0;
        end else if (acc_q) begin
            if (byte_q == SC_EXT) begin
                ext_f_q <= 1'b1;
            end else if (byte_q == SC_BRK) begin
                brk_f_q <= 1'b1;
            end else begin
                ext_f_q <= 1'b0;
                brk_f_q <= 1'b0;
            end
        end
    end

    kbd_event_t       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             full, pop, push_ok, drop;
    kbd_event_t       head;

    // A full FIFO still takes a push when the consumer pops in the same cycle.
    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign pop     = ev.ev_valid && ev.ev_ready;
    assign push_ok = ev_push && (!full || pop);
    assign drop    = ev_push && full && !pop;
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= ev_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop) begin
                cnt_q <= cnt_q + CW'(1);
            end else if (pop && !push_ok) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    assign ev.ev_valid = (cnt_q != '0);
    assign ev.ev_code  = ev.ev_valid ? head.code : 8'h00;
    assign ev.ev_ext   = ev.ev_valid && head.ext;
    assign ev.ev_break = ev.ev_valid && head.brk;
    assign ev_count    = cnt_q;

    logic             err_frame_q, err_ovf_q, held_v_q, rel_v_q;
    logic [8:0]       held_q;
    logic [7:0]       rel_q;
    logic [CNT_W-1:0] press_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_frame_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            if (frame_bad) err_frame_q <= 1'b1;
            if (drop)      err_ovf_q   <= 1'b1;
        end
    end

    // Held-key tracking follows every decoded event, even one the FIFO drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q   <= '0;
            held_v_q <= 1'b0;
            rel_q    <= '0;
            rel_v_q  <= 1'b0;
            press_q  <= '0;
        end else if (ev_push) begin
            if (!ev_new.brk) begin
                held_q   <= {ev_new.ext, ev_new.code};
                held_v_q <= 1'b1;
                if (!held_v_q || held_q != {ev_new.ext, ev_new.code}) begin
                    press_q <= press_q + CNT_W'(1);
                end
            end else begin
                rel_q   <= ev_new.code;
                rel_v_q <= 1'b1;
                if (held_v_q && held_q == {ev_new.ext, ev_new.code}) begin
                    held_v_q <= 1'b0;
                end
            end
        end
    end

    assign err_frame = err_frame_q;
    assign err_ovf   = err_ovf_q;
    assign press_cnt = press_q;

    logic [3:0] nib   [6];
    logic       blk   [6];
    logic [7:0] seg_c [6];
    logic [7:0] seg_q [6];
    logic [7:0] cnt8;

    assign cnt8 = 8'(press_q);

    always_comb begin
        nib[0] = held_q[3:0];  blk[0] = !held_v_q;
        nib[1] = held_q[7:4];  blk[1] = !held_v_q;
        nib[2] = rel_q[3:0];   blk[2] = !rel_v_q;
        nib[3] = rel_q[7:4];   blk[3] = !rel_v_q;
        nib[4] = cnt8[3:0];    blk[4] = 1'b0;
        nib[5] = cnt8[7:4];    blk[5] = 1'b0;
    end

    for (genvar i = 0; i < 6; i++) begin : g_seg
        seg7_hex u_seg (
            .hex_i     (nib[i]),
            .blank_i   (blk[i]),
            .act_low_i (SEG_ACT_LOW != 0),
            .seg_o     (seg_c[i])
        );
    end

    // Registered pins: glitch-free, and blank for as long as reset is held.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            seg_q[i] <= rst ? SEG_RST : seg_c[i];
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];

endmodule

// File: tb/tb_ps2_kbd_event_ctrl.sv
// Bench for ps2_kbd_event_ctrl: drives PS/2 frames, scoreboards events and status outputs.
module tb_ps2_kbd_event_ctrl;
    import ps2_pkg::*;

    localparam int FIFO_DEPTH  = 8;
    localparam int CNT_W       = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF        = 6;
    localparam int CW          = $clog2(FIFO_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ps2_clk = 1'b1;
    logic             ps2_data = 1'b1;
    logic [CNT_W-1:0] press_cnt;
    logic             err_frame, err_ovf;
    logic [7:0]       seg0, seg1, seg2, seg3, seg4, seg5;
    logic [CW-1:0]    ev_count;
    rx_state_t        rx_state_dbg;

    ps2_kbd_event_ctrl_if ev_if ();

    ps2_kbd_event_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH), .CNT_W (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .SEG_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev(ev_if), .press_cnt(press_cnt), .err_frame(err_frame), .err_ovf(err_ovf),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
        .ev_count(ev_count), .rx_state_dbg(rx_state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int          n_chk = 0;
    int          n_bad = 0;
    logic [9:0]  exp_q[$];
    logic        ext_m, brk_m, held_v_m, rel_v_m, err_m, ovf_m;
    logic [8:0]  held_m;
    logic [7:0]  rel_m, cnt_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] seg_exp(input logic [3:0] h, input logic blank);
        logic [7:0] p;
        case (h)
            4'h0: p = 8'h3F; 4'h1: p = 8'h06; 4'h2: p = 8'h5B; 4'h3: p = 8'h4F;
            4'h4: p = 8'h66; 4'h5: p = 8'h6D; 4'h6: p = 8'h7D; 4'h7: p = 8'h07;
            4'h8: p = 8'h7F; 4'h9: p = 8'h6F; 4'hA: p = 8'h77; 4'hB: p = 8'h7C;
            4'hC: p = 8'h39; 4'hD: p = 8'h5E; 4'hE: p = 8'h79; default: p = 8'h71;
        endcase
        if (blank) p = 8'h00;
        return ~p;
    endfunction

    task automatic model_clear();
        ext_m = 0; brk_m = 0; held_v_m = 0; rel_v_m = 0; err_m = 0; ovf_m = 0;
        held_m = '0; rel_m = '0; cnt_m = '0;
        exp_q.delete();
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [9:0] e;
        if (b == 8'hE0) begin
            ext_m = 1;
        end else if (b == 8'hF0) begin
            brk_m = 1;
        end else begin
            e = {ext_m, brk_m, b};
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(e);
            else ovf_m = 1;
            if (!brk_m) begin
                if (!held_v_m || held_m != {ext_m, b}) cnt_m = cnt_m + 8'd1;
                held_m = {ext_m, b};
                held_v_m = 1;
            end else begin
                rel_m = b;
                rel_v_m = 1;
                if (held_v_m && held_m == {ext_m, b}) held_v_m = 0;
            end
            ext_m = 0;
            brk_m = 0;
        end
    endtask

    task automatic model_bad();
        err_m = 1; ext_m = 0; brk_m = 0;
    endtask

    // Consumer side: every pop is compared with the oldest expected event.
    always @(negedge clk) begin
        if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
            if (exp_q.size() == 0) check("ev_unexpected", 32'(ev_if.ev_valid), 32'd0);
            else check("ev", 32'({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}),
                       32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
        wait_clk(HALF);
    endtask

    // mode 0: plain, 1: check ev_valid latency, 2: pop in the push cycle
    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                              input int mode);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = ~bad_stop;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(3);
        if (mode == 1) check("lat_early", 32'(ev_if.ev_valid), 32'd0);
        if (mode == 2) ev_if.ev_ready = 1'b1;
        wait_clk(1);
        if (mode == 1) check("lat_on_time", 32'(ev_if.ev_valid), 32'd1);
        ev_if.ev_ready = 1'b0;
        wait_clk(HALF - 4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_clk(HALF);
        if (!bad_par && !bad_stop) model_byte(b);
        else model_bad();
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        ev_if.ev_ready = 1'b1;
        while (ev_count != '0 && budget > 0) begin
            wait_clk(1);
            budget--;
        end
        ev_if.ev_ready = 1'b0;
        check("drain_empty", 32'(ev_count), 32'd0);
    endtask

    task automatic do_reset();
        ev_if.ev_ready = 1'b0;
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        model_clear();
        wait_clk(2);
    endtask

    task automatic check_status();
        check("press_cnt", 32'(press_cnt), 32'(cnt_m));
        check("err_frame", 32'(err_frame), 32'(err_m));
        check("err_ovf", 32'(err_ovf), 32'(ovf_m));
        check("seg0", 32'(seg0), 32'(seg_exp(held_m[3:0], !held_v_m)));
        check("seg1", 32'(seg1), 32'(seg_exp(held_m[7:4], !held_v_m)));
        check("seg2", 32'(seg2), 32'(seg_exp(rel_m[3:0], !rel_v_m)));
        check("seg3", 32'(seg3), 32'(seg_exp(rel_m[7:4], !rel_v_m)));
        check("seg4", 32'(seg4), 32'(seg_exp(cnt_m[3:0], 1'b0)));
        check("seg5", 32'(seg5), 32'(seg_exp(cnt_m[7:4], 1'b0)));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] code;
        model_clear();
        ev_if.ev_ready = 1'b0;
        rst = 1'b1;
        wait_clk(4);
        check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        check("rst_code", 32'({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}), 32'd0);
        check("rst_count", 32'(ev_count), 32'd0);
        check("rst_state", 32'(rx_state_dbg), 32'(RX_IDLE));
        check("rst_blank_all", 32'({seg0, seg1, seg2, seg3}), 32'hFFFF_FFFF);
        check("rst_blank_cnt", 32'({seg4, seg5}), 32'h0000_FFFF);
        check("rst_press", 32'(press_cnt), 32'd0);
        check("rst_errs", 32'({err_frame, err_ovf}), 32'd0);
        rst = 1'b0;
        wait_clk(3);

        // single make with latency check
        send_frame(8'h1C, 1'b0, 1'b0, 1);
        check("head_1C", 32'({ev_if.ev_ext, ev_if.ev_break, ev_if.ev_code}), 32'h01C);
        check_status();
        drain();

        // extended make then extended break
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 1'b0, 0);
        send_frame(8'hF0, 1'b0, 1'b0, 0);
        send_frame(8'h75, 1'b0, 1'b0, 0);
        check("q_ext", 32'(ev_count), 32'd2);
        check_status();
        drain();

        // typematic repeat: three events, one count
        for (int i = 0; i < 3; i++) send_frame(8'h1C, 1'b0, 1'b0, 0);
        check("q_repeat", 32'(ev_count), 32'd3);
        check_status();
        drain();

        // bad parity
        send_frame(8'($urandom_range(1, 127)), 1'b1, 1'b0, 0);
        check("badpar_q", 32'(ev_count), 32'd0);
        check_status();
        do_reset();

        // stop bit 0
        send_frame(8'($urandom_range(1, 127)), 1'b0, 1'b1, 0);
        check("badstop_q", 32'(ev_count), 32'd0);
        check_status();
        do_reset();

        // stall mid-frame: no abort before the limit, abort after it
        send_partial(4);
        wait_clk(TIMEOUT_CYC / 2);
        check("to_not_yet", 32'(err_frame), 32'd0);
        check("to_state_data", 32'(rx_state_dbg), 32'(RX_DATA));
        wait_clk(TIMEOUT_CYC);
        model_bad();
        check("to_state_idle", 32'(rx_state_dbg), 32'(RX_IDLE));
        check("to_q", 32'(ev_count), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        check_status();
        drain();

        // overflow with the consumer stalled
        do_reset();
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            code = 8'($urandom_range(1, 127));
            send_frame(code, 1'b0, 1'b0, 0);
            if (i == FIFO_DEPTH - 1) check("ovf_not_yet", 32'(err_ovf), 32'd0);
        end
        check("ovf_full", 32'(ev_count), 32'(FIFO_DEPTH));
        check_status();
        send_frame(8'($urandom_range(1, 127)), 1'b0, 1'b0, 2);
        check("ovf_pop_push", 32'(ev_count), 32'(FIFO_DEPTH));
        check_status();
        drain();

        // reset mid-frame, then a clean frame
        do_reset();
        send_partial(6);
        do_reset();
        check("midrst_state", 32'(rx_state_dbg), 32'(RX_IDLE));
        send_frame(8'h29, 1'b0, 1'b0, 0);
        check("midrst_q", 32'(ev_count), 32'd1);
        check_status();
        drain();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
